// File: rtl/execute_stage.sv
// Execute/memory stage: registered ALU results, data-memory load/store handshake, branch redirect.
// Optional ecall display register enabled by defining EXECUTE_DISPLAY_EN.
module execute_stage #(
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        aluControl_i,
  input  logic [31:0]       op1_i,
  input  logic [31:0]       op2_i,
  input  logic              mem_en_i,
  input  logic              mem_wr_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              branch_en_i,
  input  logic [19:0]       pc_imm_i,
  input  logic              displayEn_i,
  input  logic [4:0]        wbAddr_i,
  input  logic              wbEnable_i,
  output logic              dmem_req_o,
  output logic              dmem_wr_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       write_data_o,
  output logic [4:0]        wbAddr_o,
  output logic              wbEnable_o,
  output logic              branch_taken_o,
  output logic [19:0]       branch_target_o,
  output logic              stall_o,
  output logic [31:0]       display_o
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  mem_wb_addr_q;
  logic        mem_wb_en_q;
  logic [31:0] alu_result;
  logic [4:0]  shamt;

  assign shamt = op2_i[4:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_result = '0;
    case (aluControl_i)
      4'b0000: alu_result = op1_i + op2_i;
      4'b1000: alu_result = op1_i - op2_i;
      4'b0001: alu_result = op1_i << shamt;
      4'b0010: alu_result = {31'b0, $signed(op1_i) < $signed(op2_i)};
      4'b0011: alu_result = {31'b0, op1_i < op2_i};
      4'b0100: alu_result = op1_i ^ op2_i;
      4'b0101,
      4'b1011: alu_result = op1_i >> shamt;
      4'b1001,
      4'b1100: alu_result = $signed(op1_i) >>> shamt;
      4'b0110: alu_result = op1_i | op2_i;
      4'b0111: alu_result = op1_i & op2_i;
      4'b1101: alu_result = op1_i << 12;
      default: alu_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mem_en_i)     state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready_i) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  assign stall_o = (state_q == MEM_WAIT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dmem_req_o      <= 1'b0;
      dmem_wr_o       <= 1'b0;
      dmem_addr_o     <= '0;
      dmem_wdata_o    <= '0;
      write_data_o    <= '0;
      wbAddr_o        <= '0;
      wbEnable_o      <= 1'b0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
      mem_wb_addr_q   <= '0;
      mem_wb_en_q     <= 1'b0;
    end else begin
      wbEnable_o     <= 1'b0;
      branch_taken_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_en_i) begin
            dmem_req_o    <= 1'b1;
            dmem_wr_o     <= mem_wr_i;
            dmem_addr_o   <= mem_addr_i;
            dmem_wdata_o  <= op1_i;
            mem_wb_addr_q <= wbAddr_i;
            mem_wb_en_q   <= wbEnable_i;
          end else begin
            write_data_o   <= alu_result;
            wbAddr_o       <= wbAddr_i;
            wbEnable_o     <= wbEnable_i;
            branch_taken_o <= branch_en_i;
            if (branch_en_i) branch_target_o <= pc_imm_i;
          end
        end
        MEM_WAIT: begin
          // Request fields stay frozen until the memory answers.
          if (dmem_ready_i) begin
            dmem_req_o <= 1'b0;
            dmem_wr_o  <= 1'b0;
            wbAddr_o   <= mem_wb_addr_q;
            if (!dmem_wr_o) begin
              write_data_o <= dmem_rdata_i;
              wbEnable_o   <= mem_wb_en_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EXECUTE_DISPLAY_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)                                display_o <= '0;
    else if (state_q == IDLE && displayEn_i)    display_o <= op1_i;
  end
`else
  logic unused_display_en;
  assign unused_display_en = displayEn_i;
  assign display_o         = '0;
`endif

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute/memory stage of the in-order RV32I core, directly downstream of the decode stage. Consumes the registered decode bundle (ALU control, operands, memory request, branch, display, writeback tags) and performs ALU operations and data-memory loads/stores over a ready handshake. Produces the registered writeback bundle back to the register file, a branch redirect to fetch, and a pipeline stall while memory is outstanding.

## Interface
- Parameters
  - `ADDR_W`, 11: data-memory word-address width.
- Ports
  - `clk_i` in 1: single clock, rising edge.
  - `reset_i` in 1: reset is synchronous and active-high.
  - `aluControl_i` in 4: operation code from decode.
  - `op1_i`, `op2_i` in 32: signed operands.
  - `mem_en_i`, `mem_wr_i` in 1: memory access / write select.
  - `mem_addr_i` in ADDR_W: word address.
  - `branch_en_i` in 1: redirect request; `pc_imm_i` in 20: signed offset/target.
  - `displayEn_i` in 1: ecall display capture.
  - `wbAddr_i` in 5, `wbEnable_i` in 1: destination tag.
  - `dmem_req_o` out 1, `dmem_wr_o` out 1, `dmem_addr_o` out ADDR_W, `dmem_wdata_o` out 32: memory request.
  - `dmem_ready_i` in 1, `dmem_rdata_i` in 32: memory completion.
  - `write_data_o` out 32, `wbAddr_o` out 5, `wbEnable_o` out 1: writeback to register file.
  - `branch_taken_o` out 1, `branch_target_o` out 20: redirect to fetch.
  - `stall_o` out 1: holds fetch/decode.
  - `display_o` out 32: last ecall value.

## Operation
- FSM states: IDLE, MEM_WAIT.
- IDLE, `mem_en_i`=0: compute ALU result; register into `write_data_o`; copy `wbAddr_i`/`wbEnable_i`.
- ALU codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed, result 0/1), 0011 SLTU, 0100 XOR, 0101 SRL, 1001 SRA, 0110 OR, 0111 AND, 1011 SRL (imm), 1100 SRA (imm), 1101 LUI = `op1_i << 12`, 1111 NOP (result 0). Shift amount = `op2_i[4:0]`. 32-bit wrap on ADD/SUB, no overflow flag. Unlisted codes behave as NOP.
- IDLE, `mem_en_i`=1: latch addr, `mem_wr_i`, `op1_i` (store data), `wbAddr_i`/`wbEnable_i`; drive `dmem_req_o`=1 next cycle; go MEM_WAIT; `wbEnable_o`=0 meanwhile.
- MEM_WAIT: hold `dmem_*` stable, `stall_o`=1, ignore all decode inputs. On `dmem_ready_i`=1: deassert req next cycle, return IDLE; load → `write_data_o`=`dmem_rdata_i`, `wbEnable_o`=latched enable for one cycle; store → `wbEnable_o`=0.
- `branch_en_i` in IDLE: `branch_taken_o`=1 one cycle, `branch_target_o`=`pc_imm_i`; JAL link value (`op1_i`+`op2_i`) written back as a normal ADD.
- `displayEn_i` in IDLE: `display_o` ← `op1_i` (see Configuration).
- Reset: state IDLE; all outputs 0; reset inside MEM_WAIT abandons the access (req drops next edge, no writeback).

## Timing
- ALU/branch/display: inputs sampled at edge N, outputs valid after edge N (1-cycle latency), no stall.
- Memory: edge N capture → `dmem_req_o`, `stall_o` high from N; completion at edge N+1+k (k = cycles before ready); writeback valid for one cycle after that edge; `stall_o` low in same cycle.
- `dmem_ready_i` same cycle as req rising (k=0): legal, 2-cycle load latency total.
- `dmem_ready_i` while not requesting: ignored.
- `wbEnable_o` is a single-cycle pulse per retired instruction; `branch_taken_o` never asserted in MEM_WAIT.

## Configuration
- `EXECUTE_DISPLAY_EN` defined: `display_o` is a 32-bit register updated by `displayEn_i`, reset 0.
- Undefined: no display register; `display_o` tied to 0; `displayEn_i` ignored.

## Test plan
- ADD op1=5, op2=-7, wbAddr=3, en=1 → next cycle write_data_o=0xFFFFFFFE, wbAddr_o=3, wbEnable_o=1.
- SRA op1=0x80000000, op2=4 → 0xF8000000; SLTU op1=-1, op2=1 → 0; LUI op1=0x12345 → 0x12345000.
- Load addr 0x10, ready after 3 cycles with rdata=0xDEADBEEF → stall_o high 4 cycles, then write_data_o=0xDEADBEEF, wbEnable_o pulse 1 cycle.
- Store op1=0xA5A5, addr 0x7FF, ready same cycle as req → dmem_wr_o=1, dmem_wdata_o=0xA5A5, wbEnable_o stays 0, stall 1 cycle.
- Branch pc_imm=-8 → branch_taken_o=1 one cycle, branch_target_o=0xFFFF8.
- Reset asserted during MEM_WAIT → next edge dmem_req_o=0, stall_o=0, no writeback; ecall op1=42 with macro → display_o=42, without → 0.
